nios_system_pio_bank: RTL and testbench

Parametrised multi-channel Avalon-MM output-port bank for the Nios II system; the successor to the single-register output PIOs that drive accelerator operands such as the SHA address. It provides CHANNELS independent WIDTH-bit output registers, each with atomic bit-set/bit-clear access and a valid/ack handshake to the consuming hardware. Sticky overrun status tells software when it rewrote a value the consumer had not yet taken. The block sits on the system interconnect as a zero-wait-state slave.

---
 rtl/nios_system_pio_bank_pkg.sv | 23 ++
 rtl/nios_system_pio_bank_if.sv | 26 ++
 rtl/nios_system_pio_bank_chan.sv | 108 ++++++++++
 rtl/nios_system_pio_bank.sv | 96 +++++++++
 tb/tb_nios_system_pio_bank.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_pio_bank_pkg.sv
// Shared constants and types for the PIO bank: register offsets, STATUS bit
// positions, parameter limits and the per-channel handshake state.
package nios_system_pio_pkg;

  localparam logic [1:0] PIO_OFF_DATA   = 2'd0;
  localparam logic [1:0] PIO_OFF_SET    = 2'd1;
  localparam logic [1:0] PIO_OFF_CLR    = 2'd2;
  localparam logic [1:0] PIO_OFF_STATUS = 2'd3;

  localparam int PIO_ST_PEND = 0;
  localparam int PIO_ST_OVR  = 1;
  localparam int PIO_ST_IEN  = 2;
  localparam int PIO_ST_DONE = 3;

  localparam int PIO_MAX_CHANNELS = 8;
  localparam int PIO_MAX_WIDTH    = 32;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PEND = 1'b1
  } chanState_e;

endpackage

// File: rtl/nios_system_pio_bank_if.sv
// Avalon-MM slave bus plus the per-channel output/handshake signals of the PIO bank.
interface nios_system_pio_bank_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int AW = $clog2(CHANNELS) + 2;

  logic [AW-1:0]             address;
  logic                      chipselect;
  logic                      write_n;
  logic [31:0]               writedata;
  logic [31:0]               readdata;
  logic [CHANNELS*WIDTH-1:0] out_port;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ack;

  modport master (
    output address, chipselect, write_n, writedata, out_ack,
    input  readdata, out_port, out_valid
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ack,
    output readdata, out_port, out_valid
  );
endinterface

// File: rtl/nios_system_pio_bank_chan.sv
// One PIO channel: data register with set/clear, valid/ack handshake FSM and sticky status.
// PIO_BANK_IRQ_EN adds the done and irq_en flops; otherwise they read as 0.
module nios_system_pio_chan
  import nios_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dataWr_i,
  input  logic [1:0]       dataOp_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             statusWr_i,
  input  logic [3:0]       statusData_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o,
  output logic             overrun_o,
  output logic             irqEn_o,
  output logic             done_o
);

  chanState_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             ackTaken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CH_IDLE;
      data_q    <= RESET_VALUE;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  // A data write always wins over a same-cycle ack; hardware set beats the W1C clear.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    ackTaken  = 1'b0;
    if (statusWr_i && statusData_i[PIO_ST_OVR]) overrun_d = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (dataWr_i) state_d = CH_PEND;
      end
      CH_PEND: begin
        if (dataWr_i) begin
          if (!ack_i) overrun_d = 1'b1;
        end else if (ack_i) begin
          state_d  = CH_IDLE;
          ackTaken = 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
    if (dataWr_i) begin
      case (dataOp_i)
        PIO_OFF_SET: data_d = data_q | wrData_i;
        PIO_OFF_CLR: data_d = data_q & ~wrData_i;
        default:     data_d = wrData_i;
      endcase
    end
  end

  assign data_o    = data_q;
  assign pending_o = (state_q == CH_PEND);
  assign overrun_o = overrun_q;

`ifdef PIO_BANK_IRQ_EN
  logic done_q, done_d;
  logic irqEn_q, irqEn_d;

  always_comb begin
    done_d  = done_q;
    irqEn_d = irqEn_q;
    if (statusWr_i) begin
      irqEn_d = statusData_i[PIO_ST_IEN];
      if (statusData_i[PIO_ST_DONE]) done_d = 1'b0;
    end
    if (ackTaken) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 1'b0;
      irqEn_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      irqEn_q <= irqEn_d;
    end
  end

  assign done_o  = done_q;
  assign irqEn_o = irqEn_q;
`else
  logic unusedSt;
  assign unusedSt = ^{statusData_i[3:2], ackTaken};
  assign done_o   = 1'b0;
  assign irqEn_o  = 1'b0;
`endif

endmodule

// File: rtl/nios_system_pio_bank.sv
// Multi-channel Avalon-MM output-port bank: address decode, read mux and channel array.
// Define PIO_BANK_IRQ_EN to add the registered irq output and STATUS done/irq_en bits.
module nios_system_pio_bank
  import nios_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               CHANNELS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                   clk,
  input logic                   reset_n,
  nios_system_pio_bank_if.slave bus
`ifdef PIO_BANK_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(CHANNELS) + 2;

  logic [AW-1:0]       wordIdx;
  logic [1:0]          regOff;
  logic                chanOk;
  logic                busWr;
  logic [WIDTH-1:0]    chanData [CHANNELS];
  logic [CHANNELS-1:0] pend, ovr, ien, done;
  logic [31:0]         rdData;
  logic                unusedWd;

  assign wordIdx  = bus.address >> 2;
  assign regOff   = bus.address[1:0];
  assign chanOk   = (wordIdx < AW'(CHANNELS));
  assign busWr    = bus.chipselect && !bus.write_n && chanOk;
  assign unusedWd = ^bus.writedata;

  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    logic sel;
    assign sel = busWr && (wordIdx == AW'(c));

    nios_system_pio_chan #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) uChan (
      .clk          (clk),
      .reset_n      (reset_n),
      .dataWr_i     (sel && (regOff != PIO_OFF_STATUS)),
      .dataOp_i     (regOff),
      .wrData_i     (bus.writedata[WIDTH-1:0]),
      .statusWr_i   (sel && (regOff == PIO_OFF_STATUS)),
      .statusData_i (bus.writedata[3:0]),
      .ack_i        (bus.out_ack[c]),
      .data_o       (chanData[c]),
      .pending_o    (pend[c]),
      .overrun_o    (ovr[c]),
      .irqEn_o      (ien[c]),
      .done_o       (done[c])
    );

    assign bus.out_port[c*WIDTH +: WIDTH] = chanData[c];
  end

  assign bus.out_valid = pend;

  // Read path is purely combinational, so it shows state from before the current edge.
  always_comb begin
    rdData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chanOk && (wordIdx == AW'(c))) begin
        if (regOff == PIO_OFF_STATUS) begin
          rdData[PIO_ST_PEND] = pend[c];
          rdData[PIO_ST_OVR]  = ovr[c];
          rdData[PIO_ST_IEN]  = ien[c];
          rdData[PIO_ST_DONE] = done[c];
        end else begin
          rdData = 32'(chanData[c]);
        end
      end
    end
  end

  assign bus.readdata = rdData;

`ifdef PIO_BANK_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |(done & ien);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_nios_system_pio_bank.sv
// Self-checking bench for nios_system_pio_bank (3 channels, so index 3 is out of range).
// Directed steps then random traffic, compared against a register-level reference model.
module tb_nios_system_pio_bank;

  localparam int          WIDTH   = 32;
  localparam int          CHN     = 3;
  localparam int          AW      = $clog2(CHN) + 2;
  localparam logic [31:0] RST_VAL = 32'h0000_A5A5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  nios_system_pio_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHN)) bus ();
`ifdef PIO_BANK_IRQ_EN
  logic irq;
`endif

  nios_system_pio_bank #(
    .WIDTH       (WIDTH),
    .CHANNELS    (CHN),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef PIO_BANK_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one entry per channel holding the architectural register values.
  logic [31:0] mData [CHN];
  bit          mPend [CHN];
  bit          mOvr  [CHN];
  bit          mIen  [CHN];
  bit          mDone [CHN];
  bit          mIrq;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < CHN; c++) begin
      mData[c] = RST_VAL;
      mPend[c] = 1'b0;
      mOvr[c]  = 1'b0;
      mIen[c]  = 1'b0;
      mDone[c] = 1'b0;
    end
    mIrq = 1'b0;
  endfunction

  function automatic logic [31:0] expectedRead(input int addr);
    int          ch  = addr / 4;
    int          off = addr % 4;
    logic [31:0] r   = '0;
    if (ch < CHN) begin
      if (off == 3) begin
        r[0] = mPend[ch];
        r[1] = mOvr[ch];
`ifdef PIO_BANK_IRQ_EN
        r[2] = mIen[ch];
        r[3] = mDone[ch];
`endif
      end else begin
        r = mData[ch];
      end
    end
    return r;
  endfunction

  function automatic logic [CHN*32-1:0] expectedPort();
    logic [CHN*32-1:0] p;
    for (int c = 0; c < CHN; c++) p[c*32 +: 32] = mData[c];
    return p;
  endfunction

  function automatic logic [CHN-1:0] expectedValid();
    logic [CHN-1:0] v;
    for (int c = 0; c < CHN; c++) v[c] = mPend[c];
    return v;
  endfunction

  // Effect of one clock edge on the registers, taken straight from the register rules.
  function automatic void modelStep(input bit wr, input int addr, input logic [31:0] wd,
                                    input logic [CHN-1:0] ack);
    int ch  = addr / 4;
    int off = addr % 4;
    bit anyIrq = 1'b0;
    for (int c = 0; c < CHN; c++) anyIrq |= (mDone[c] & mIen[c]);
    for (int c = 0; c < CHN; c++) begin
      bit dataWrite = wr && (ch == c) && (off != 3);
      bit statWrite = wr && (ch == c) && (off == 3);
      bit ackEff    = ack[c] && mPend[c] && !dataWrite;
      if (statWrite) begin
        if (wd[1]) mOvr[c] = 1'b0;
        if (wd[3]) mDone[c] = 1'b0;
        mIen[c] = wd[2];
      end
      if (dataWrite && mPend[c] && !ack[c]) mOvr[c] = 1'b1;
      if (ackEff) mDone[c] = 1'b1;
      if (dataWrite) begin
        if (off == 0)      mData[c] = wd;
        else if (off == 1) mData[c] = mData[c] | wd;
        else               mData[c] = mData[c] & ~wd;
        mPend[c] = 1'b1;
      end else if (ackEff) begin
        mPend[c] = 1'b0;
      end
    end
    mIrq = anyIrq;
  endfunction

  // Entered at a falling edge; drives one bus cycle and checks before and after the rising edge.
  task automatic applyStimulus(input bit wr, input int addr, input logic [31:0] wd,
                               input logic [CHN-1:0] ack);
    int pick;
    if (wr) begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
    end else begin
      pick = $urandom_range(0, 2);
      bus.chipselect = (pick == 1);
      bus.write_n    = (pick != 0);
    end
    bus.address   = AW'(addr);
    bus.writedata = wd;
    bus.out_ack   = ack;
    #1;
    checkOutput($sformatf("readdata@%0h", addr), bus.readdata, expectedRead(addr));
    @(posedge clk);
    modelStep(wr, addr, wd, ack);
    #1;
    checkOutput("out_port", bus.out_port, expectedPort());
    checkOutput("out_valid", bus.out_valid, expectedValid());
`ifdef PIO_BANK_IRQ_EN
    checkOutput("irq", irq, mIrq);
`endif
    @(negedge clk);
  endtask

  // Asynchronous reset with ack held high throughout, which must be ignored.
  task automatic doReset();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.address    = AW'(7);
    bus.out_ack    = '1;
    reset_n        = 1'b0;
    #1;
    modelReset();
    checkOutput("reset out_valid", bus.out_valid, expectedValid());
    checkOutput("reset out_port", bus.out_port, expectedPort());
    checkOutput("reset status ch1", bus.readdata, expectedRead(7));
`ifdef PIO_BANK_IRQ_EN
    checkOutput("reset irq", irq, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    bus.out_ack = '0;
    reset_n     = 1'b1;
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.out_ack    = '0;
    modelReset();
    @(negedge clk);
    doReset();

    $display("[TB] reset readback of every offset");
    for (int a = 0; a < 16; a++) applyStimulus(1'b0, a, 32'h0, '0);

    $display("[TB] ch1 DATA write and ack");
    applyStimulus(1'b1, 4, 32'hDEAD_BEEF, '0);
    checkOutput("ch1 out_port", bus.out_port[63:32], 32'hDEAD_BEEF);
    checkOutput("ch1 valid", bus.out_valid[1], 1'b1);
    applyStimulus(1'b0, 4, 32'h0, 3'b010);
    checkOutput("ch1 valid after ack", bus.out_valid[1], 1'b0);

    $display("[TB] ch0 set/clear");
    applyStimulus(1'b1, 0, 32'h0000_00F0, '0);
    applyStimulus(1'b1, 1, 32'h0000_000F, '0);
    applyStimulus(1'b1, 2, 32'h0000_00C0, '0);
    applyStimulus(1'b0, 0, 32'h0, '0);
    checkOutput("ch0 data", bus.readdata, 32'h0000_003F);

    $display("[TB] ch2 overrun and W1C");
    applyStimulus(1'b1, 8, 32'h1, '0);
    applyStimulus(1'b1, 8, 32'h2, '0);
    applyStimulus(1'b0, 11, 32'h0, '0);
    checkOutput("ch2 status overrun", bus.readdata, 32'h3);
    applyStimulus(1'b1, 11, 32'h2, '0);
    applyStimulus(1'b0, 11, 32'h0, '0);
    checkOutput("ch2 status w1c", bus.readdata, 32'h1);
    applyStimulus(1'b1, 8, 32'h5, 3'b100);
    applyStimulus(1'b0, 11, 32'h0, '0);
    checkOutput("ch2 ack+write", bus.readdata, 32'h1);

    $display("[TB] out-of-range channel");
    applyStimulus(1'b1, 12, 32'h1234_5678, '0);
    applyStimulus(1'b0, 12, 32'h0, '0);
    checkOutput("ch3 read", bus.readdata, 32'h0);

`ifdef PIO_BANK_IRQ_EN
    $display("[TB] irq path");
    applyStimulus(1'b1, 3, 32'h4, '0);
    applyStimulus(1'b1, 0, 32'h55, '0);
    applyStimulus(1'b0, 0, 32'h0, 3'b001);
    applyStimulus(1'b0, 3, 32'h0, '0);
    checkOutput("irq set", irq, 1'b1);
    applyStimulus(1'b1, 3, 32'hC, '0);
    applyStimulus(1'b0, 3, 32'h0, '0);
    checkOutput("irq cleared", irq, 1'b0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
                    CHN'($urandom_range(0, 7)));
    end

    $display("[TB] reset mid-handshake");
    applyStimulus(1'b1, 4, 32'h0000_CAFE, '0);
    checkOutput("ch1 pending before reset", bus.out_valid[1], 1'b1);
    doReset();
    applyStimulus(1'b0, 7, 32'h0, '0);
    applyStimulus(1'b0, 4, 32'h0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
